// File: rtl/packet_sorter_pkg.sv
// packet_sorter_pkg: types and the key-compare helper shared by the packet sorter.
//   sorter_state_e : control states (idle, fill, drain)
//   cell_op_e      : per-cell array operation (hold, load, shift up, shift down)
//   key_before()   : true when word a must be output strictly before word b
package packet_sorter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain
    } sorter_state_e;

    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpShiftUp,
        OpShiftDown
    } cell_op_e;

    // Widest key the compare helper handles; callers zero-extend to this width.
    localparam int unsigned MaxKeyWidth = 64;

    // Strict ordering, so equal keys never reorder and arrival order is preserved.
    // Signed keys are compared as offset binary: flipping the sign bit of a
    // zero-extended value makes an unsigned compare match two's-complement order.
    function automatic logic key_before(input logic [MaxKeyWidth-1:0] a,
                                        input logic [MaxKeyWidth-1:0] b,
                                        input int unsigned            width,
                                        input bit                     descending,
                                        input bit                     signed_keys);
        logic [MaxKeyWidth-1:0] sign_bit;
        logic [MaxKeyWidth-1:0] ka;
        logic [MaxKeyWidth-1:0] kb;
        sign_bit = signed_keys ? (MaxKeyWidth'(1) << (width - 1)) : '0;
        ka       = a ^ sign_bit;
        kb       = b ^ sign_bit;
        return descending ? (ka > kb) : (ka < kb);
    endfunction

endpackage

// File: rtl/psort_cell.sv
// psort_cell: one slot of the sorting array. No reset; the controller never
// exposes a slot that the current packet has not written.
//   snk_clock  : clock
//   op         : hold / load load_data / shift up (take below_data) / shift down (take above_data)
//   load_data  : incoming word
//   below_data : contents of the next lower slot
//   above_data : contents of the next higher slot
//   cell_data  : current contents
module psort_cell
    import packet_sorter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  snk_clock,
    input  cell_op_e              op,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [DATA_WIDTH-1:0] below_data,
    input  logic [DATA_WIDTH-1:0] above_data,
    output logic [DATA_WIDTH-1:0] cell_data
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        unique case (op)
            OpLoad:      data_d = load_data;
            OpShiftUp:   data_d = below_data;
            OpShiftDown: data_d = above_data;
            default:     data_d = data_q;
        endcase
    end

    always_ff @(posedge snk_clock) begin
        data_q <= data_d;
    end

    assign cell_data = data_q;

endmodule

// File: rtl/packet_sorter.sv
// packet_sorter: collects one packet into a register array kept sorted on every
// insertion, then streams it out in sort order.
//   snk_clock / snk_reset : clock, asynchronous active-high reset
//   snk_data/valid/sop/eop/ready : input stream
//   src_data/valid/sop/eop/ready : sorted output stream
//   src_ovf : packet was truncated to MAX_LENGTH words (qualified by src_eop)
module packet_sorter
    import packet_sorter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_LENGTH  = 32,
    parameter bit          DESCENDING  = 1'b0,
    parameter bit          SIGNED_KEYS = 1'b0
) (
    input  logic                  snk_clock,
    input  logic                  snk_reset,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_valid,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    output logic                  snk_ready,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_valid,
    output logic                  src_sop,
    output logic                  src_eop,
    input  logic                  src_ready,
    output logic                  src_ovf
);

    localparam int unsigned            CountWidth = $clog2(MAX_LENGTH + 1);
    localparam logic [CountWidth-1:0] MaxCount   = CountWidth'(MAX_LENGTH);
    localparam logic [CountWidth-1:0] OneCount   = CountWidth'(1);

    sorter_state_e         state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  first_q, first_d;

    logic                  snk_accept, src_accept;
    logic                  restart, insert_en, shift_down_en;
    logic [MAX_LENGTH-1:0] after_new, after_below;
    logic [DATA_WIDTH-1:0] cell_data [MAX_LENGTH];
    cell_op_e              cell_op   [MAX_LENGTH];

    assign snk_ready  = (state_q != StDrain);
    assign src_valid  = (state_q == StDrain);
    assign snk_accept = snk_valid && snk_ready;
    assign src_accept = src_valid && src_ready;

    // Outside drain the array may hold stale words, so they are masked off.
    assign src_data = src_valid ? cell_data[0] : '0;
    assign src_sop  = src_valid && first_q;
    assign src_eop  = src_valid && (count_q == OneCount);
    assign src_ovf  = src_eop && ovf_q;

    // Occupied cells whose word must follow the new word; in a sorted array
    // these form a contiguous upper run, which moves up by one.
    always_comb begin
        after_new = '0;
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            after_new[i] = (CountWidth'(i) < count_q) &&
                           key_before(MaxKeyWidth'(snk_data), MaxKeyWidth'(cell_data[i]),
                                      DATA_WIDTH, DESCENDING, SIGNED_KEYS);
        end
    end

    assign after_below = {after_new[MAX_LENGTH-2:0], 1'b0};

    // The new word lands in the lowest cell of that run, or at the end of the
    // occupied region when nothing has to move.
    always_comb begin
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            cell_op[i] = OpHold;
            if (shift_down_en) begin
                cell_op[i] = OpShiftDown;
            end else if (restart) begin
                if (i == 0) cell_op[i] = OpLoad;
            end else if (insert_en) begin
                if (after_below[i]) begin
                    cell_op[i] = OpShiftUp;
                end else if (after_new[i] || (CountWidth'(i) == count_q)) begin
                    cell_op[i] = OpLoad;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        first_d       = first_q;
        restart       = 1'b0;
        insert_en     = 1'b0;
        shift_down_en = 1'b0;
        unique case (state_q)
            StIdle, StFill: begin
                if (snk_accept && snk_sop) begin
                    // A new sop always starts a fresh packet, abandoning any partial one.
                    restart = 1'b1;
                    count_d = OneCount;
                    ovf_d   = 1'b0;
                    state_d = StFill;
                end else if (snk_accept && (state_q == StFill)) begin
                    if (count_q != MaxCount) begin
                        insert_en = 1'b1;
                        count_d   = count_q + OneCount;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if ((state_d == StFill) && snk_accept && snk_eop) begin
                    state_d = StDrain;
                    first_d = 1'b1;
                end
            end
            StDrain: begin
                if (src_accept) begin
                    shift_down_en = 1'b1;
                    count_d       = count_q - OneCount;
                    first_d       = 1'b0;
                    if (count_q == OneCount) begin
                        state_d = StIdle;
                        ovf_d   = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge snk_clock or posedge snk_reset) begin
        if (snk_reset) begin
            state_q <= StIdle;
            count_q <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

    for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_cell
        logic [DATA_WIDTH-1:0] below_data;
        logic [DATA_WIDTH-1:0] above_data;

        if (g == 0) begin : g_bottom
            assign below_data = '0;
        end else begin : g_lower
            assign below_data = cell_data[g-1];
        end

        if (g == MAX_LENGTH - 1) begin : g_top
            assign above_data = '0;
        end else begin : g_upper
            assign above_data = cell_data[g+1];
        end

        psort_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .snk_clock (snk_clock),
            .op        (cell_op[g]),
            .load_data (snk_data),
            .below_data(below_data),
            .above_data(above_data),
            .cell_data (cell_data[g])
        );
    end

endmodule

// File: tb/tb_packet_sorter.sv
// tb_packet_sorter: three sorter configurations driven side by side.
//   inst 0: 32-bit, 32 words, ascending unsigned
//   inst 1: 8-bit, 8 words, descending signed
//   inst 2: 8-bit, 4 words, ascending unsigned (truncation)
// A per-instance reference keeps the words of the open packet, ranks them when
// the packet closes, and the negedge monitor compares every output cycle.
module tb_packet_sorter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       rst, snk_valid, snk_sop, snk_eop, snk_ready;
    logic [NI-1:0]       src_valid, src_sop, src_eop, src_ready, src_ovf;
    logic [NI-1:0][31:0] snk_data, src_data;
    logic [31:0]         src_data0;
    logic [7:0]          src_data1, src_data2;

    assign src_data[0] = src_data0;
    assign src_data[1] = {24'h0, src_data1};
    assign src_data[2] = {24'h0, src_data2};

    packet_sorter u_dut0 (
        .snk_clock(clk), .snk_reset(rst[0]), .snk_data(snk_data[0]),
        .snk_valid(snk_valid[0]), .snk_sop(snk_sop[0]), .snk_eop(snk_eop[0]),
        .snk_ready(snk_ready[0]), .src_data(src_data0), .src_valid(src_valid[0]),
        .src_sop(src_sop[0]), .src_eop(src_eop[0]), .src_ready(src_ready[0]),
        .src_ovf(src_ovf[0])
    );

    packet_sorter #(
        .DATA_WIDTH(8), .MAX_LENGTH(8), .DESCENDING(1'b1), .SIGNED_KEYS(1'b1)
    ) u_dut1 (
        .snk_clock(clk), .snk_reset(rst[1]), .snk_data(snk_data[1][7:0]),
        .snk_valid(snk_valid[1]), .snk_sop(snk_sop[1]), .snk_eop(snk_eop[1]),
        .snk_ready(snk_ready[1]), .src_data(src_data1), .src_valid(src_valid[1]),
        .src_sop(src_sop[1]), .src_eop(src_eop[1]), .src_ready(src_ready[1]),
        .src_ovf(src_ovf[1])
    );

    packet_sorter #(
        .DATA_WIDTH(8), .MAX_LENGTH(4), .DESCENDING(1'b0), .SIGNED_KEYS(1'b0)
    ) u_dut2 (
        .snk_clock(clk), .snk_reset(rst[2]), .snk_data(snk_data[2][7:0]),
        .snk_valid(snk_valid[2]), .snk_sop(snk_sop[2]), .snk_eop(snk_eop[2]),
        .snk_ready(snk_ready[2]), .src_data(src_data2), .src_valid(src_valid[2]),
        .src_sop(src_sop[2]), .src_eop(src_eop[2]), .src_ready(src_ready[2]),
        .src_ovf(src_ovf[2])
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] part_d  [NI][64];
    int          part_n  [NI];
    bit          in_pkt  [NI];
    bit          m_ovf   [NI];
    logic [31:0] exp_d   [NI][64];
    int          exp_len [NI];
    int          exp_pos [NI];
    bit          exp_ovf [NI];
    logic [31:0] log_d   [NI][256];
    bit          log_sop [NI][256];
    bit          log_eop [NI][256];
    bit          log_ovf [NI][256];
    int          log_n   [NI];

    function automatic int cfg_w(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic int cfg_len(input int k);
        return (k == 0) ? 32 : ((k == 1) ? 8 : 4);
    endfunction

    function automatic bit cfg_desc(input int k);
        return k == 1;
    endfunction

    function automatic bit cfg_sgn(input int k);
        return k == 1;
    endfunction

    function automatic logic [31:0] mask(input int k);
        logic [31:0] m;
        m = '1;
        return m >> (32 - cfg_w(k));
    endfunction

    // Sort key as a plain integer: lower key is output first.
    function automatic longint key_of(input int k, input logic [31:0] d);
        longint v;
        longint w;
        w = longint'(cfg_w(k));
        v = longint'(d & mask(k));
        if (cfg_sgn(k) && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return cfg_desc(k) ? -v : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Position of each word = number of words that must precede it.
    task automatic finalize(input int k);
        int r;
        for (int j = 0; j < part_n[k]; j++) begin
            r = 0;
            for (int i = 0; i < part_n[k]; i++) begin
                if (key_of(k, part_d[k][i]) < key_of(k, part_d[k][j]) ||
                    (key_of(k, part_d[k][i]) == key_of(k, part_d[k][j]) && i < j)) r++;
            end
            exp_d[k][r] = part_d[k][j];
        end
        exp_len[k] = part_n[k];
        exp_pos[k] = 0;
        exp_ovf[k] = m_ovf[k];
        in_pkt[k]  = 1'b0;
        part_n[k]  = 0;
    endtask

    task automatic beat(input int k);
        logic [31:0] d;
        d = snk_data[k] & mask(k);
        if (snk_sop[k]) begin
            part_d[k][0] = d;
            part_n[k]    = 1;
            in_pkt[k]    = 1'b1;
            m_ovf[k]     = 1'b0;
        end else if (in_pkt[k]) begin
            if (part_n[k] < cfg_len(k)) begin
                part_d[k][part_n[k]] = d;
                part_n[k]++;
            end else begin
                m_ovf[k] = 1'b1;
            end
        end
        if (in_pkt[k] && snk_eop[k]) finalize(k);
    endtask

    task automatic step(input int k);
        bit pending;
        int pos;
        bit last;
        if (rst[k]) begin
            in_pkt[k]  = 1'b0;
            part_n[k]  = 0;
            m_ovf[k]   = 1'b0;
            exp_len[k] = 0;
            exp_pos[k] = 0;
            chk1($sformatf("rst_src_valid[%0d]", k), src_valid[k], 1'b0);
            chk1($sformatf("rst_src_sop[%0d]", k), src_sop[k], 1'b0);
            chk1($sformatf("rst_src_eop[%0d]", k), src_eop[k], 1'b0);
            chk1($sformatf("rst_src_ovf[%0d]", k), src_ovf[k], 1'b0);
            chk1($sformatf("rst_snk_ready[%0d]", k), snk_ready[k], 1'b1);
            chk($sformatf("rst_src_data[%0d]", k), src_data[k], 32'h0);
            return;
        end
        pending = exp_pos[k] < exp_len[k];
        chk1($sformatf("snk_ready[%0d]", k), snk_ready[k], !pending);
        chk1($sformatf("src_valid[%0d]", k), src_valid[k], pending);
        if (pending) begin
            pos  = exp_pos[k];
            last = (pos == exp_len[k] - 1);
            chk($sformatf("src_data[%0d]", k), src_data[k], exp_d[k][pos]);
            chk1($sformatf("src_sop[%0d]", k), src_sop[k], pos == 0);
            chk1($sformatf("src_eop[%0d]", k), src_eop[k], last);
            chk1($sformatf("src_ovf[%0d]", k), src_ovf[k], last && exp_ovf[k]);
            if (src_ready[k]) begin
                if (log_n[k] < 256) begin
                    log_d[k][log_n[k]]   = src_data[k];
                    log_sop[k][log_n[k]] = src_sop[k];
                    log_eop[k][log_n[k]] = src_eop[k];
                    log_ovf[k][log_n[k]] = src_ovf[k];
                end
                log_n[k]++;
                exp_pos[k]++;
            end
        end else if (snk_valid[k]) begin
            beat(k);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) step(k);
    end

    task automatic send(input int k, input logic [31:0] d, input bit sop, input bit eop);
        snk_valid[k] = 1'b1;
        snk_data[k]  = d;
        snk_sop[k]   = sop;
        snk_eop[k]   = eop;
        @(posedge clk);
        #1;
        snk_valid[k] = 1'b0;
        snk_sop[k]   = 1'b0;
        snk_eop[k]   = 1'b0;
    endtask

    task automatic send_pkt(input int k, input logic [31:0] w [8], input int n);
        for (int i = 0; i < n; i++) send(k, w[i], i == 0, i == n - 1);
    endtask

    task automatic wait_idle(input int k);
        int c;
        c = 0;
        while (exp_pos[k] < exp_len[k] && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk1($sformatf("drain_timeout[%0d]", k), snk_ready[k], 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Literal expectation on the n-th word logged since base.
    task automatic chk_log(input string name, input int k, input int idx,
                           input logic [31:0] d, input bit sop, input bit eop, input bit ovf);
        bit have;
        have = idx < log_n[k];
        chk({name, "_data"}, have ? log_d[k][idx] : 32'hDEAD_BEEF, d);
        chk1({name, "_sop"}, have ? log_sop[k][idx] : 1'bx, sop);
        chk1({name, "_eop"}, have ? log_eop[k][idx] : 1'bx, eop);
        chk1({name, "_ovf"}, have ? log_ovf[k][idx] : 1'bx, ovf);
    endtask

    initial begin
        int base;
        logic [31:0] w [8];
        rst       = '1;
        snk_valid = '0;
        snk_sop   = '0;
        snk_eop   = '0;
        snk_data  = '0;
        src_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = '0;
        @(posedge clk);
        #1;

        // 5,3,9,1 ascending
        base = log_n[0];
        w = '{32'd5, 32'd3, 32'd9, 32'd1, 0, 0, 0, 0};
        send_pkt(0, w, 4);
        @(negedge clk);
        chk1("t1_latency_valid", src_valid[0], 1'b1);
        chk1("t1_drain_ready", snk_ready[0], 1'b0);
        wait_idle(0);
        chk("t1_count", 32'(log_n[0] - base), 32'd4);
        chk_log("t1_w0", 0, base + 0, 32'd1, 1'b1, 1'b0, 1'b0);
        chk_log("t1_w1", 0, base + 1, 32'd3, 1'b0, 1'b0, 1'b0);
        chk_log("t1_w2", 0, base + 2, 32'd5, 1'b0, 1'b0, 1'b0);
        chk_log("t1_w3", 0, base + 3, 32'd9, 1'b0, 1'b1, 1'b0);

        // Signed descending 0x7F,0x80,0x00
        base = log_n[1];
        w = '{32'h7F, 32'h80, 32'h00, 0, 0, 0, 0, 0};
        send_pkt(1, w, 3);
        wait_idle(1);
        chk_log("t2_w0", 1, base + 0, 32'h7F, 1'b1, 1'b0, 1'b0);
        chk_log("t2_w1", 1, base + 1, 32'h00, 1'b0, 1'b0, 1'b0);
        chk_log("t2_w2", 1, base + 2, 32'h80, 1'b0, 1'b1, 1'b0);

        // Truncation at 4 words: 6..1
        base = log_n[2];
        w = '{32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 0, 0};
        send_pkt(2, w, 6);
        wait_idle(2);
        chk("t3_count", 32'(log_n[2] - base), 32'd4);
        chk_log("t3_w0", 2, base + 0, 32'd3, 1'b1, 1'b0, 1'b0);
        chk_log("t3_w1", 2, base + 1, 32'd4, 1'b0, 1'b0, 1'b0);
        chk_log("t3_w2", 2, base + 2, 32'd5, 1'b0, 1'b0, 1'b0);
        chk_log("t3_w3", 2, base + 3, 32'd6, 1'b0, 1'b1, 1'b1);

        // Single-beat packet
        base = log_n[0];
        send(0, 32'hA5, 1'b1, 1'b1);
        wait_idle(0);
        chk("t4_count", 32'(log_n[0] - base), 32'd1);
        chk_log("t4_w0", 0, base, 32'hA5, 1'b1, 1'b1, 1'b0);

        // Backpressure: src_ready toggles every cycle
        base = log_n[0];
        src_ready[0] = 1'b0;
        w = '{32'd2, 32'd1, 0, 0, 0, 0, 0, 0};
        send_pkt(0, w, 2);
        @(negedge clk);
        chk("t5_stall_data", src_data[0], 32'd1);
        chk1("t5_stall_ready", snk_ready[0], 1'b0);
        for (int c = 0; c < 40 && exp_pos[0] < exp_len[0]; c++) begin
            @(posedge clk);
            #1;
            src_ready[0] = ~src_ready[0];
        end
        src_ready[0] = 1'b1;
        wait_idle(0);
        chk_log("t5_w0", 0, base + 0, 32'd1, 1'b1, 1'b0, 1'b0);
        chk_log("t5_w1", 0, base + 1, 32'd2, 1'b0, 1'b1, 1'b0);

        // Reset mid-drain after one output word, then a fresh packet
        base = log_n[0];
        src_ready[0] = 1'b0;
        w = '{32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 0};
        send_pkt(0, w, 3);
        src_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        #1;
        chk1("t6_valid_after_reset", src_valid[0], 1'b0);
        chk("t6_words_before_reset", 32'(log_n[0] - base), 32'd1);
        chk_log("t6_w0", 0, base, 32'd1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        base = log_n[0];
        w = '{32'd8, 32'd7, 0, 0, 0, 0, 0, 0};
        send_pkt(0, w, 2);
        wait_idle(0);
        chk_log("t6_w1", 0, base + 0, 32'd7, 1'b1, 1'b0, 1'b0);
        chk_log("t6_w2", 0, base + 1, 32'd8, 1'b0, 1'b1, 1'b0);

        // Random traffic on all instances with occasional resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < NI; k++) begin
                rst[k]       = ($urandom_range(0, 299) == 0);
                snk_valid[k] = ($urandom_range(0, 3) != 0);
                snk_sop[k]   = ($urandom_range(0, 6) == 0);
                snk_eop[k]   = ($urandom_range(0, (k == 0) ? 14 : 4) == 0);
                snk_data[k]  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
                src_ready[k] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk);
            #1;
        end
        rst       = '0;
        snk_valid = '0;
        src_ready = '1;
        for (int k = 0; k < NI; k++) wait_idle(k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
